node_theta: RTL and testbench

NODE_THETA -- requirements
Module: node_theta

---
 rtl/node_pkg.sv | 11 +
 rtl/node_theta_if.sv | 31 +++
 rtl/node_state_chain.sv | 44 ++++
 rtl/node_theta.sv | 68 ++++++
 tb/tb_node_theta.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/node_pkg.sv
// Shared types for the node_theta block: combine-function select encoding.
package node_pkg;

  typedef enum logic [1:0] {
    MODE_ANDN = 2'd0,
    MODE_XOR  = 2'd1,
    MODE_OR   = 2'd2,
    MODE_PASS = 2'd3
  } node_mode_e;

endpackage

// File: rtl/node_theta_if.sv
// Valid/ready stream bundle for node_theta: one input beat channel and one
// registered result channel. The master side is the producer/consumer
// environment; the slave side is the node itself.
interface node_theta_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_vec;

  modport master (
    output in_valid,
    output in_vec,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_vec
  );

  modport slave (
    input  in_valid,
    input  in_vec,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_vec
  );
endinterface

// File: rtl/node_state_chain.sv
// History chain s[0..DEPTH-1] plus the mode-selected combine of its two ends.
// The chain only moves on an accepted beat; flush zeroes it synchronously.
module node_state_chain
  import node_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             accept,
  input  node_mode_e       mode,
  input  logic [WIDTH-1:0] in_vec,
  output logic [WIDTH-1:0] computed
);

  logic [WIDTH-1:0] s [DEPTH];

  // Combine the head and tail of the chain according to the selected mode.
  always_comb begin
    computed = s[0];
    case (mode)
      MODE_ANDN: computed = s[0] & ~s[DEPTH-1];
      MODE_XOR:  computed = s[0] ^ s[DEPTH-1];
      MODE_OR:   computed = s[0] | s[DEPTH-1];
      MODE_PASS: computed = s[0];
      default:   computed = s[0];
    endcase
  end

  // Advance the chain on each accepted beat; head folds in the combine result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) s[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) s[i] <= '0;
    end else if (accept) begin
      s[0] <= in_vec | computed;
      for (int i = 1; i < DEPTH; i++) s[i] <= s[i-1] ^ in_vec;
    end
  end

endmodule

// File: rtl/node_theta.sv
// node_theta: accepts one beat per cycle, folds it through a short history
// chain and presents (computed + in_vec) as a registered, back-pressurable
// result. Also counts accepted beats.
module node_theta
  import node_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  node_mode_e       mode,
  output logic [CNT_W-1:0] beat_count,
  node_theta_if.slave      bus
);

  logic             accept_p0;
  logic [WIDTH-1:0] computed_p0;
  logic [WIDTH-1:0] out_vec_p1;
  logic             vld_p1;

  // A new beat may enter when the output slot is free or draining, never during flush.
  assign bus.in_ready = (!vld_p1 || bus.out_ready) && !flush;
  assign accept_p0    = bus.in_valid && bus.in_ready;

  node_state_chain #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_chain (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .accept   (accept_p0),
    .mode     (mode),
    .in_vec   (bus.in_vec),
    .computed (computed_p0)
  );

  // ---- p0 -> p1: result register; holds while downstream stalls, flush leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      out_vec_p1 <= '0;
    end else if (accept_p0) begin
      vld_p1     <= 1'b1;
      out_vec_p1 <= computed_p0 + bus.in_vec;
    end else if (bus.out_ready) begin
      vld_p1     <= 1'b0;
    end
  end

  // Accepted-beat counter, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_count <= '0;
    end else if (flush) begin
      beat_count <= '0;
    end else if (accept_p0) begin
      beat_count <= beat_count + CNT_W'(1);
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_vec   = out_vec_p1;

endmodule

// File: tb/tb_node_theta.sv
// Directed bench for node_theta with WIDTH=8, DEPTH=2, CNT_W=4.
module tb_node_theta;
  import node_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       flush;
  node_mode_e mode;
  logic [3:0] beat_count;
  int         total;
  int         bad;

  node_theta_if #(.WIDTH(8)) bus ();

  node_theta #(
    .WIDTH (8),
    .DEPTH (2),
    .CNT_W (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .mode       (mode),
    .beat_count (beat_count),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one valid beat for exactly one edge, then sample 1ns after the edge.
  task automatic send_beat(input logic [1:0] m, input logic [7:0] v);
    mode         = node_mode_e'(m);
    bus.in_vec   = v;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_vec    = 8'h00;
    bus.out_ready = 1'b1;
    mode          = MODE_ANDN;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", bus.out_valid); end
    total++; if (bus.out_vec !== 8'h00) begin bad++; $display("FAIL reset_out_vec got=%h want=00", bus.out_vec); end
    total++; if (beat_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", beat_count); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", bus.in_ready); end
  endtask

  task automatic test_modes();
    do_reset();
    send_beat(2'd0, 8'h0F);
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL andn_valid got=%0b want=1", bus.out_valid); end
    total++; if (bus.out_vec !== 8'h0F) begin bad++; $display("FAIL andn_vec got=%h want=0f", bus.out_vec); end
    send_beat(2'd2, 8'h01);
    total++; if (bus.out_vec !== 8'h10) begin bad++; $display("FAIL or_vec got=%h want=10", bus.out_vec); end
    send_beat(2'd3, 8'hF0);
    total++; if (bus.out_vec !== 8'hFF) begin bad++; $display("FAIL pass_vec got=%h want=ff", bus.out_vec); end
    // s0=ff, s1=ff now: xor gives 00, so result is just the input
    send_beat(2'd1, 8'h5A);
    total++; if (bus.out_vec !== 8'h5A) begin bad++; $display("FAIL xor_vec got=%h want=5a", bus.out_vec); end
    total++; if (beat_count !== 4'd4) begin bad++; $display("FAIL modes_count got=%0d want=4", beat_count); end
    @(posedge clk);
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL drain_valid got=%0b want=0", bus.out_valid); end
  endtask

  task automatic test_sum_wrap();
    do_reset();
    send_beat(2'd3, 8'hF0);
    total++; if (bus.out_vec !== 8'hF0) begin bad++; $display("FAIL wrap_first got=%h want=f0", bus.out_vec); end
    send_beat(2'd3, 8'h20);
    total++; if (bus.out_vec !== 8'h10) begin bad++; $display("FAIL wrap_second got=%h want=10", bus.out_vec); end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.out_ready = 1'b0;
    send_beat(2'd0, 8'h0F);
    total++; if (bus.out_vec !== 8'h0F || bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_first got=%h/%0b want=0f/1", bus.out_vec, bus.out_valid); end
    mode         = MODE_ANDN;
    bus.in_vec   = 8'h33;
    bus.in_valid = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%0b want=0", bus.in_ready); end
    @(posedge clk);
    #1;
    total++; if (bus.out_vec !== 8'h0F) begin bad++; $display("FAIL bp_hold_vec got=%h want=0f", bus.out_vec); end
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid got=%0b want=1", bus.out_valid); end
    total++; if (beat_count !== 4'd1) begin bad++; $display("FAIL bp_hold_count got=%0d want=1", beat_count); end
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%0b want=1", bus.in_ready); end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    total++; if (bus.out_vec !== 8'h33) begin bad++; $display("FAIL bp_second_vec got=%h want=33", bus.out_vec); end
    total++; if (beat_count !== 4'd2) begin bad++; $display("FAIL bp_second_count got=%0d want=2", beat_count); end
  endtask

  task automatic test_flush();
    do_reset();
    send_beat(2'd3, 8'h01);
    send_beat(2'd3, 8'h02);
    send_beat(2'd3, 8'h03);
    total++; if (bus.out_vec !== 8'h06) begin bad++; $display("FAIL fl_third got=%h want=06", bus.out_vec); end
    total++; if (beat_count !== 4'd3) begin bad++; $display("FAIL fl_count3 got=%0d want=3", beat_count); end
    bus.out_ready = 1'b0;
    flush         = 1'b1;
    bus.in_vec    = 8'h77;
    bus.in_valid  = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL fl_in_ready got=%0b want=0", bus.in_ready); end
    @(posedge clk);
    #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    total++; if (beat_count !== 4'd0) begin bad++; $display("FAIL fl_count got=%0d want=0", beat_count); end
    total++; if (bus.out_valid !== 1'b1 || bus.out_vec !== 8'h06) begin bad++; $display("FAIL fl_pending got=%h/%0b want=06/1", bus.out_vec, bus.out_valid); end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL fl_drained got=%0b want=0", bus.out_valid); end
    send_beat(2'd0, 8'h0F);
    total++; if (bus.out_vec !== 8'h0F) begin bad++; $display("FAIL fl_after got=%h want=0f", bus.out_vec); end
    total++; if (beat_count !== 4'd1) begin bad++; $display("FAIL fl_after_count got=%0d want=1", beat_count); end
  endtask

  task automatic test_count_wrap_reset();
    do_reset();
    for (int i = 0; i < 15; i++) send_beat(2'd3, 8'(i));
    total++; if (beat_count !== 4'd15) begin bad++; $display("FAIL cnt_15 got=%0d want=15", beat_count); end
    send_beat(2'd3, 8'h0F);
    total++; if (beat_count !== 4'd0) begin bad++; $display("FAIL cnt_wrap got=%0d want=0", beat_count); end
    bus.out_ready = 1'b0;
    send_beat(2'd3, 8'hAA);
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL rst_pre_valid got=%0b want=1", bus.out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_async_valid got=%0b want=0", bus.out_valid); end
    total++; if (bus.out_vec !== 8'h00) begin bad++; $display("FAIL rst_async_vec got=%h want=00", bus.out_vec); end
    total++; if (beat_count !== 4'd0) begin bad++; $display("FAIL rst_async_count got=%0d want=0", beat_count); end
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    send_beat(2'd0, 8'h0F);
    total++; if (bus.out_vec !== 8'h0F) begin bad++; $display("FAIL rst_first_beat got=%h want=0f", bus.out_vec); end
    total++; if (beat_count !== 4'd1) begin bad++; $display("FAIL rst_first_count got=%0d want=1", beat_count); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_modes();
    test_sum_wrap();
    test_backpressure();
    test_flush();
    test_count_wrap_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
